// File: rtl/avmm_axil_bridge_if.sv
// Bus bundles for the Avalon-MM to AXI4-Lite bridge: the Avalon-MM command side
// and the AXI4-Lite master side, each with master/slave views.
interface avmm_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   avmm_address;
  logic [DATA_W-1:0]   avmm_writedata;
  logic [DATA_W/8-1:0] avmm_byteenable;
  logic                avmm_write;
  logic                avmm_read;
  logic                avmm_waitrequest;
  logic [DATA_W-1:0]   avmm_readdata;
  logic [1:0]          avmm_response;

  modport master (
    output avmm_address, avmm_writedata, avmm_byteenable, avmm_write, avmm_read,
    input  avmm_waitrequest, avmm_readdata, avmm_response
  );
  modport slave (
    input  avmm_address, avmm_writedata, avmm_byteenable, avmm_write, avmm_read,
    output avmm_waitrequest, avmm_readdata, avmm_response
  );
endinterface

interface axil_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   m_axil_awaddr;
  logic [2:0]          m_axil_awprot;
  logic                m_axil_awvalid;
  logic                m_axil_awready;
  logic [DATA_W-1:0]   m_axil_wdata;
  logic [DATA_W/8-1:0] m_axil_wstrb;
  logic                m_axil_wvalid;
  logic                m_axil_wready;
  logic [1:0]          m_axil_bresp;
  logic                m_axil_bvalid;
  logic                m_axil_bready;
  logic [ADDR_W-1:0]   m_axil_araddr;
  logic [2:0]          m_axil_arprot;
  logic                m_axil_arvalid;
  logic                m_axil_arready;
  logic [DATA_W-1:0]   m_axil_rdata;
  logic [1:0]          m_axil_rresp;
  logic                m_axil_rvalid;
  logic                m_axil_rready;

  modport master (
    output m_axil_awaddr, m_axil_awprot, m_axil_awvalid, input m_axil_awready,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid, input m_axil_wready,
    input  m_axil_bresp, m_axil_bvalid, output m_axil_bready,
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid, input m_axil_arready,
    input  m_axil_rdata, m_axil_rresp, m_axil_rvalid, output m_axil_rready
  );
  modport slave (
    input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid, output m_axil_awready,
    input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid, output m_axil_wready,
    output m_axil_bresp, m_axil_bvalid, input m_axil_bready,
    input  m_axil_araddr, m_axil_arprot, m_axil_arvalid, output m_axil_arready,
    output m_axil_rdata, m_axil_rresp, m_axil_rvalid, input m_axil_rready
  );
endinterface

// File: rtl/avmm_axil_bridge.sv
// Avalon-MM slave to AXI4-Lite master bridge: one AXI transaction per Avalon
// command, completion signalled by a single-cycle waitrequest drop.
module avmm_axil_bridge #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  avmm_if.slave      avmm,
  axil_if.master     m_axil,
  output logic [7:0] err_count
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ACK} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic [7:0]          err_q, err_d;
  logic                cap;
  logic [1:0]          cap_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    err_d     = err_q;
    cap       = 1'b0;
    cap_resp  = 2'b00;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (avmm.avmm_write) begin
          addr_d  = avmm.avmm_address;
          wdata_d = avmm.avmm_writedata;
          wstrb_d = avmm.avmm_byteenable;
          state_d = WR_REQ;
        end else if (avmm.avmm_read) begin
          addr_d  = avmm.avmm_address;
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave once both have handshaken
        if (m_axil.m_axil_awvalid && m_axil.m_axil_awready) aw_done_d = 1'b1;
        if (m_axil.m_axil_wvalid && m_axil.m_axil_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axil.m_axil_bvalid) begin
          resp_d   = m_axil.m_axil_bresp;
          cap      = 1'b1;
          cap_resp = m_axil.m_axil_bresp;
          state_d  = ACK;
        end
      end
      RD_REQ: begin
        if (m_axil.m_axil_arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (m_axil.m_axil_rvalid) begin
          rdata_d  = m_axil.m_axil_rdata;
          resp_d   = m_axil.m_axil_rresp;
          cap      = 1'b1;
          cap_resp = m_axil.m_axil_rresp;
          state_d  = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cap && (cap_resp != 2'b00) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  // Handshake outputs decode the state register so reset clears them at once
  assign avmm.avmm_waitrequest = (state_q != ACK);
  assign avmm.avmm_readdata    = rdata_q;
  assign avmm.avmm_response    = resp_q;

  assign m_axil.m_axil_awaddr  = addr_q;
  assign m_axil.m_axil_awprot  = 3'b000;
  assign m_axil.m_axil_awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign m_axil.m_axil_wdata   = wdata_q;
  assign m_axil.m_axil_wstrb   = wstrb_q;
  assign m_axil.m_axil_wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign m_axil.m_axil_bready  = (state_q == WR_RESP);
  assign m_axil.m_axil_araddr  = addr_q;
  assign m_axil.m_axil_arprot  = 3'b000;
  assign m_axil.m_axil_arvalid = (state_q == RD_REQ);
  assign m_axil.m_axil_rready  = (state_q == RD_RESP);

  assign err_count = err_q;
endmodule

// File: tb/tb_avmm_axil_bridge.sv
// Directed self-checking bench for avmm_axil_bridge; cycle 0 is the cycle in
// which the Avalon request is first presented.
module tb_avmm_axil_bridge;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_count;
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  avmm_if #(.ADDR_W(17), .DATA_W(32)) av ();
  axil_if #(.ADDR_W(17), .DATA_W(32)) ax ();

  avmm_axil_bridge #(.ADDR_W(17), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .avmm      (av),
    .m_axil    (ax),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_ready(input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
    ax.m_axil_awready = 1'b1;
    ax.m_axil_wready  = 1'b1;
    ax.m_axil_bvalid  = 1'b1;
    ax.m_axil_bresp   = br;
    ax.m_axil_arready = 1'b1;
    ax.m_axil_rvalid  = 1'b1;
    ax.m_axil_rresp   = rr;
    ax.m_axil_rdata   = rd;
  endtask

  task automatic slave_idle();
    ax.m_axil_awready = 1'b0;
    ax.m_axil_wready  = 1'b0;
    ax.m_axil_bvalid  = 1'b0;
    ax.m_axil_bresp   = 2'b00;
    ax.m_axil_arready = 1'b0;
    ax.m_axil_rvalid  = 1'b0;
    ax.m_axil_rresp   = 2'b00;
    ax.m_axil_rdata   = '0;
  endtask

  // Minimum-latency write: request at cycle 0, ACK at cycle 3, released there
  task automatic quick_write(input logic [16:0] a, input logic [31:0] d, input logic [1:0] br);
    slave_ready(br, 2'b00, 32'h0);
    av.avmm_address = a; av.avmm_writedata = d; av.avmm_byteenable = 4'hF;
    av.avmm_write = 1'b1;
    tick(); tick(); tick();
    av.avmm_write = 1'b0;
    tick();
  endtask

  task automatic quick_read(input logic [16:0] a, input logic [31:0] d, input logic [1:0] rr);
    slave_ready(2'b00, rr, d);
    av.avmm_address = a;
    av.avmm_read = 1'b1;
    tick(); tick(); tick();
    av.avmm_read = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    av.avmm_address = '0; av.avmm_writedata = '0; av.avmm_byteenable = '0;
    av.avmm_write = 1'b0; av.avmm_read = 1'b0;
    slave_idle();
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();

    // Reset / idle state
    chk("rst_waitreq", av.avmm_waitrequest, 1'b1);
    chk("rst_awvalid", ax.m_axil_awvalid, 1'b0);
    chk("rst_wvalid",  ax.m_axil_wvalid, 1'b0);
    chk("rst_arvalid", ax.m_axil_arvalid, 1'b0);
    chk("rst_bready",  ax.m_axil_bready, 1'b0);
    chk("rst_rready",  ax.m_axil_rready, 1'b0);
    chk("rst_err",     err_count, 8'd0);
    chk("rst_rdata",   av.avmm_readdata, 32'h0);
    chk("rst_resp",    av.avmm_response, 2'b00);

    // Minimum-latency write
    slave_ready(2'b00, 2'b00, 32'h0);
    av.avmm_address = 17'h00104; av.avmm_writedata = 32'hDEADBEEF;
    av.avmm_byteenable = 4'hF; av.avmm_write = 1'b1;
    chk("w0_waitreq_c0", av.avmm_waitrequest, 1'b1);
    tick();
    chk("w0_awvalid_c1", ax.m_axil_awvalid, 1'b1);
    chk("w0_wvalid_c1",  ax.m_axil_wvalid, 1'b1);
    chk("w0_awaddr_c1",  ax.m_axil_awaddr, 17'h00104);
    chk("w0_wdata_c1",   ax.m_axil_wdata, 32'hDEADBEEF);
    chk("w0_wstrb_c1",   ax.m_axil_wstrb, 4'hF);
    chk("w0_awprot_c1",  ax.m_axil_awprot, 3'b000);
    chk("w0_waitreq_c1", av.avmm_waitrequest, 1'b1);
    tick();
    chk("w0_bready_c2",  ax.m_axil_bready, 1'b1);
    chk("w0_awvalid_c2", ax.m_axil_awvalid, 1'b0);
    chk("w0_waitreq_c2", av.avmm_waitrequest, 1'b1);
    tick();
    chk("w0_waitreq_c3", av.avmm_waitrequest, 1'b0);
    chk("w0_resp_c3",    av.avmm_response, 2'b00);
    av.avmm_write = 1'b0;
    tick();
    chk("w0_waitreq_c4", av.avmm_waitrequest, 1'b1);
    chk("w0_awvalid_c4", ax.m_axil_awvalid, 1'b0);

    // Write with wready one cycle late and awready four cycles late
    slave_idle();
    av.avmm_address = 17'h1ABCD; av.avmm_writedata = 32'h0F0F0F0F;
    av.avmm_byteenable = 4'h5; av.avmm_write = 1'b1;
    tick();
    chk("w1_awvalid_c1", ax.m_axil_awvalid, 1'b1);
    chk("w1_wvalid_c1",  ax.m_axil_wvalid, 1'b1);
    tick();
    ax.m_axil_wready = 1'b1;
    chk("w1_wvalid_c2",  ax.m_axil_wvalid, 1'b1);
    tick();
    ax.m_axil_wready = 1'b0;
    chk("w1_wvalid_c3",  ax.m_axil_wvalid, 1'b0);
    chk("w1_awvalid_c3", ax.m_axil_awvalid, 1'b1);
    chk("w1_awaddr_c3",  ax.m_axil_awaddr, 17'h1ABCD);
    tick();
    chk("w1_awvalid_c4", ax.m_axil_awvalid, 1'b1);
    chk("w1_bready_c4",  ax.m_axil_bready, 1'b0);
    tick();
    ax.m_axil_awready = 1'b1;
    chk("w1_awvalid_c5", ax.m_axil_awvalid, 1'b1);
    tick();
    ax.m_axil_awready = 1'b0;
    ax.m_axil_bvalid = 1'b1; ax.m_axil_bresp = 2'b00;
    chk("w1_awvalid_c6", ax.m_axil_awvalid, 1'b0);
    chk("w1_bready_c6",  ax.m_axil_bready, 1'b1);
    chk("w1_waitreq_c6", av.avmm_waitrequest, 1'b1);
    tick();
    chk("w1_waitreq_c7", av.avmm_waitrequest, 1'b0);
    av.avmm_write = 1'b0; ax.m_axil_bvalid = 1'b0;
    tick();
    chk("w1_waitreq_c8", av.avmm_waitrequest, 1'b1);

    // Read with three wait cycles before rvalid
    slave_idle();
    ax.m_axil_arready = 1'b1;
    av.avmm_address = 17'h00200; av.avmm_read = 1'b1;
    tick();
    chk("r0_arvalid_c1", ax.m_axil_arvalid, 1'b1);
    chk("r0_araddr_c1",  ax.m_axil_araddr, 17'h00200);
    chk("r0_awvalid_c1", ax.m_axil_awvalid, 1'b0);
    tick();
    chk("r0_rready_c2",  ax.m_axil_rready, 1'b1);
    chk("r0_arvalid_c2", ax.m_axil_arvalid, 1'b0);
    tick(); tick();
    chk("r0_waitreq_c4", av.avmm_waitrequest, 1'b1);
    tick();
    ax.m_axil_rvalid = 1'b1; ax.m_axil_rdata = 32'h12345678; ax.m_axil_rresp = 2'b00;
    tick();
    ax.m_axil_rvalid = 1'b0; ax.m_axil_rdata = 32'hFFFFFFFF;
    chk("r0_waitreq_c6", av.avmm_waitrequest, 1'b0);
    chk("r0_rdata_c6",   av.avmm_readdata, 32'h12345678);
    chk("r0_resp_c6",    av.avmm_response, 2'b00);
    av.avmm_read = 1'b0;
    tick();
    chk("r0_waitreq_c7", av.avmm_waitrequest, 1'b1);
    chk("r0_rdata_hold", av.avmm_readdata, 32'h12345678);

    // Error responses and counter
    quick_write(17'h00008, 32'hAAAA5555, 2'b10);
    chk("e_wr_resp",     av.avmm_response, 2'b10);
    chk("e_wr_rdata",    av.avmm_readdata, 32'h12345678);
    chk("e_err1",        err_count, 8'd1);
    quick_read(17'h0000C, 32'hCAFE0000, 2'b11);
    chk("e_rd_resp",     av.avmm_response, 2'b11);
    chk("e_rd_rdata",    av.avmm_readdata, 32'hCAFE0000);
    chk("e_err2",        err_count, 8'd2);
    for (int i = 0; i < 252; i++) quick_write(17'h00010, 32'h1, 2'b10);
    chk("e_err254",      err_count, 8'd254);
    for (int i = 0; i < 46; i++) quick_write(17'h00010, 32'h1, 2'b11);
    chk("e_err_sat",     err_count, 8'd255);
    quick_write(17'h00014, 32'h2, 2'b00);
    chk("e_ok_resp",     av.avmm_response, 2'b00);
    chk("e_err_hold",    err_count, 8'd255);

    // Write and read together: write wins
    slave_ready(2'b00, 2'b00, 32'h55555555);
    av.avmm_address = 17'h00300; av.avmm_writedata = 32'h00C0FFEE;
    av.avmm_byteenable = 4'h3; av.avmm_write = 1'b1; av.avmm_read = 1'b1;
    tick();
    chk("b_awvalid_c1", ax.m_axil_awvalid, 1'b1);
    chk("b_wvalid_c1",  ax.m_axil_wvalid, 1'b1);
    chk("b_wstrb_c1",   ax.m_axil_wstrb, 4'h3);
    chk("b_arvalid_c1", ax.m_axil_arvalid, 1'b0);
    tick();
    chk("b_arvalid_c2", ax.m_axil_arvalid, 1'b0);
    chk("b_bready_c2",  ax.m_axil_bready, 1'b1);
    tick();
    chk("b_waitreq_c3", av.avmm_waitrequest, 1'b0);
    chk("b_rdata_c3",   av.avmm_readdata, 32'hCAFE0000);
    av.avmm_write = 1'b0; av.avmm_read = 1'b0;
    tick();
    chk("b_arvalid_c4", ax.m_axil_arvalid, 1'b0);
    chk("b_rready_c4",  ax.m_axil_rready, 1'b0);

    // Asynchronous reset while waiting in WR_RESP
    slave_idle();
    ax.m_axil_awready = 1'b1; ax.m_axil_wready = 1'b1;
    av.avmm_address = 17'h00400; av.avmm_writedata = 32'h1; av.avmm_write = 1'b1;
    tick(); tick();
    chk("x_bready_pre",  ax.m_axil_bready, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("x_bready_rst",  ax.m_axil_bready, 1'b0);
    chk("x_waitreq_rst", av.avmm_waitrequest, 1'b1);
    chk("x_awvalid_rst", ax.m_axil_awvalid, 1'b0);
    chk("x_err_rst",     err_count, 8'd0);
    chk("x_resp_rst",    av.avmm_response, 2'b00);
    av.avmm_write = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("x_arvalid_post", ax.m_axil_arvalid, 1'b0);
    chk("x_waitreq_post", av.avmm_waitrequest, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
